// File: rtl/picorv32_pcpi_router.sv
// Routes PCPI M-extension requests to a multiplier or a divider and merges the response.
// Optional macro PCPI_ROUTER_RESP_REG_EN registers the response through an extra RESP cycle.
module picorv32_pcpi_router #(
  parameter int unsigned ENABLE_MUL      = 1,
  parameter int unsigned ENABLE_DIV      = 1,
  parameter int unsigned WATCHDOG_CYCLES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        pcpi_err,
  output logic        mul_valid,
  output logic        div_valid,
  output logic [31:0] unit_insn,
  output logic [31:0] unit_rs1,
  output logic [31:0] unit_rs2,
  input  logic        mul_wr,
  input  logic        mul_ready,
  input  logic        div_wr,
  input  logic        div_ready,
  input  logic [31:0] mul_rd,
  input  logic [31:0] div_rd,
  input  logic        mul_wait,
  input  logic        div_wait
);

  localparam bit MUL_EN = (ENABLE_MUL != 0);
  localparam bit DIV_EN = (ENABLE_DIV != 0);
  localparam bit WD_EN  = (WATCHDOG_CYCLES != 0);
  localparam int unsigned CW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(WATCHDOG_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_RESP, S_DRAIN} state_t;

  state_t        state;
  logic          sel;       // 0 = multiplier, 1 = divider
  logic [CW-1:0] wd_cnt;
  logic          wait_q;
  logic          req_match;
  logic          sel_ready;
  logic          sel_wr;
  logic [31:0]   sel_rd;
  logic          wd_expire;
  logic          unused_wait;

  // Unit stall lines carry no information the router needs.
  assign unused_wait = mul_wait ^ div_wait;

  assign req_match = pcpi_valid
                  && (pcpi_insn[6:0]   == 7'b0110011)
                  && (pcpi_insn[31:25] == 7'b0000001)
                  && (pcpi_insn[14] ? DIV_EN : MUL_EN);

  assign sel_ready = sel ? div_ready : mul_ready;
  assign sel_wr    = sel ? div_wr    : mul_wr;
  assign sel_rd    = sel ? div_rd    : mul_rd;
  assign wd_expire = WD_EN && (wd_cnt == WD_LAST);

`ifdef PCPI_ROUTER_RESP_REG_EN
  logic        ready_q;
  logic        wr_q;
  logic        err_q;
  logic [31:0] rd_q;
`endif

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      sel       <= 1'b0;
      wd_cnt    <= '0;
      wait_q    <= 1'b0;
      mul_valid <= 1'b0;
      div_valid <= 1'b0;
      unit_insn <= '0;
      unit_rs1  <= '0;
      unit_rs2  <= '0;
`ifdef PCPI_ROUTER_RESP_REG_EN
      ready_q   <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_match) begin
            state     <= S_DISPATCH;
            sel       <= pcpi_insn[14];
            wd_cnt    <= '0;
            wait_q    <= 1'b1;
            mul_valid <= MUL_EN && !pcpi_insn[14];
            div_valid <= DIV_EN &&  pcpi_insn[14];
            unit_insn <= pcpi_insn;
            unit_rs1  <= pcpi_rs1;
            unit_rs2  <= pcpi_rs2;
          end
        end
        S_DISPATCH: begin
          wd_cnt <= wd_cnt + CW'(1);
          if (!pcpi_valid) begin
            // Core withdrew the request; any later unit response is dropped.
            state     <= S_IDLE;
            wait_q    <= 1'b0;
            mul_valid <= 1'b0;
            div_valid <= 1'b0;
          end else if (sel_ready || wd_expire) begin
            mul_valid <= 1'b0;
            div_valid <= 1'b0;
`ifdef PCPI_ROUTER_RESP_REG_EN
            state   <= S_RESP;
            ready_q <= 1'b1;
            rd_q    <= sel_ready ? sel_rd : '0;
            wr_q    <= sel_ready && sel_wr;
            err_q   <= !sel_ready;
`else
            state   <= S_DRAIN;
            wait_q  <= 1'b0;
`endif
          end
        end
        S_RESP: begin
          state  <= S_DRAIN;
          wait_q <= 1'b0;
`ifdef PCPI_ROUTER_RESP_REG_EN
          ready_q <= 1'b0;
          wr_q    <= 1'b0;
          err_q   <= 1'b0;
          rd_q    <= '0;
`endif
        end
        S_DRAIN: begin
          if (!pcpi_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pcpi_wait = wait_q;

`ifdef PCPI_ROUTER_RESP_REG_EN
  assign pcpi_ready = ready_q;
  assign pcpi_wr    = wr_q;
  assign pcpi_err   = err_q;
  assign pcpi_rd    = rd_q;
`else
  logic resp_now;

  // Response is forwarded in the same cycle the unit (or watchdog) finishes.
  assign resp_now   = (state == S_DISPATCH) && pcpi_valid && (sel_ready || wd_expire);
  assign pcpi_ready = resp_now;
  assign pcpi_wr    = resp_now && sel_ready && sel_wr;
  assign pcpi_err   = resp_now && !sel_ready;
  assign pcpi_rd    = (resp_now && sel_ready) ? sel_rd : '0;
`endif

endmodule

// File: tb/tb_picorv32_pcpi_router.sv
// Self-checking bench for picorv32_pcpi_router: one instance with both units enabled and one
// with the divider disabled, both with an 8-cycle watchdog, driven from a shared stub.
module tb_picorv32_pcpi_router;

  localparam int WD = 8;
`ifdef PCPI_ROUTER_RESP_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        mul_wr, mul_ready, div_wr, div_ready, mul_wait, div_wait;
  logic [31:0] mul_rd, div_rd;

  logic        a_wr, a_wait, a_ready, a_err, a_mul_valid, a_div_valid;
  logic [31:0] a_rd, a_unit_insn, a_unit_rs1, a_unit_rs2;
  logic        b_wr, b_wait, b_ready, b_err, b_mul_valid, b_div_valid;
  logic [31:0] b_rd, b_unit_insn, b_unit_rs1, b_unit_rs2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  picorv32_pcpi_router #(.ENABLE_MUL(1), .ENABLE_DIV(1), .WATCHDOG_CYCLES(WD)) dut_a (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(a_wr), .pcpi_rd(a_rd),
    .pcpi_wait(a_wait), .pcpi_ready(a_ready), .pcpi_err(a_err),
    .mul_valid(a_mul_valid), .div_valid(a_div_valid), .unit_insn(a_unit_insn),
    .unit_rs1(a_unit_rs1), .unit_rs2(a_unit_rs2), .mul_wr(mul_wr), .mul_ready(mul_ready),
    .div_wr(div_wr), .div_ready(div_ready), .mul_rd(mul_rd), .div_rd(div_rd),
    .mul_wait(mul_wait), .div_wait(div_wait));

  picorv32_pcpi_router #(.ENABLE_MUL(1), .ENABLE_DIV(0), .WATCHDOG_CYCLES(WD)) dut_b (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(b_wr), .pcpi_rd(b_rd),
    .pcpi_wait(b_wait), .pcpi_ready(b_ready), .pcpi_err(b_err),
    .mul_valid(b_mul_valid), .div_valid(b_div_valid), .unit_insn(b_unit_insn),
    .unit_rs1(b_unit_rs1), .unit_rs2(b_unit_rs2), .mul_wr(mul_wr), .mul_ready(mul_ready),
    .div_wr(div_wr), .div_ready(div_ready), .mul_rd(mul_rd), .div_rd(div_rd),
    .mul_wait(mul_wait), .div_wait(div_wait));

  // Architectural RV32M result, used as the stub units' answer.
  function automatic logic [31:0] m_ref(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    r  = '0;
    p  = '0;
    case (f3)
      3'd0: begin p = za * zb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * zb; r = p[63:32]; end
      3'd3: begin p = za * zb; r = p[63:32]; end
      3'd4: if (b == 0) r = '1;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else r = $signed(a) / $signed(b);
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
            else r = $signed(a) % $signed(b);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // One core request held for its whole life; stub answers on cycle 'lat' (0 = never).
  task automatic run_txn(input string name, input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input int lat, input logic [31:0] res,
                         input logic res_wr, input int hold);
    bit m_op, is_div, served, claim_a, claim_b, fire, disp, wait_c, rdy_c;
    int d, resp_c, total;
    logic [31:0] exp_rd;
    bit exp_wr, exp_err;
    logic [5:0] exp_ctrl, obs_ctrl;
    logic [31:0] exp_d;
    m_op    = (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001);
    is_div  = insn[14];
    served  = (lat >= 1) && (lat <= WD);
    d       = served ? lat : WD;
    resp_c  = d + EXTRA;
    total   = m_op ? resp_c + 1 + hold : hold;
    claim_a = m_op;
    claim_b = m_op && !is_div;
    exp_rd  = served ? res : 32'd0;
    exp_wr  = served && res_wr;
    exp_err = !served;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      pcpi_valid = 1'b1;
      pcpi_insn  = insn;
      pcpi_rs1   = rs1;
      pcpi_rs2   = rs2;
      fire = m_op && (lat >= 1) && (c == lat);
      if (is_div) begin
        div_ready = fire;
        div_rd    = fire ? res : $urandom;
        div_wr    = fire ? res_wr : 1'($urandom_range(0, 1));
        mul_ready = 1'($urandom_range(0, 1));
        mul_rd    = $urandom;
        mul_wr    = 1'($urandom_range(0, 1));
      end else begin
        mul_ready = fire;
        mul_rd    = fire ? res : $urandom;
        mul_wr    = fire ? res_wr : 1'($urandom_range(0, 1));
        div_ready = 1'($urandom_range(0, 1));
        div_rd    = $urandom;
        div_wr    = 1'($urandom_range(0, 1));
      end
      mul_wait = 1'($urandom_range(0, 1));
      div_wait = 1'($urandom_range(0, 1));
      #1;
      disp   = (c >= 1) && (c <= d);
      wait_c = (c >= 1) && (c <= resp_c);
      rdy_c  = (c == resp_c);

      exp_ctrl = {claim_a && !is_div && disp, claim_a && is_div && disp, claim_a && wait_c,
                  claim_a && rdy_c, claim_a && rdy_c && exp_wr, claim_a && rdy_c && exp_err};
      obs_ctrl = {a_mul_valid, a_div_valid, a_wait, a_ready, a_wr, a_err};
      checks++;
      if (obs_ctrl !== exp_ctrl) begin
        failures++;
        $display("FAIL %s cyc%0d ctrl_a(mv,dv,wait,rdy,wr,err) got=%b exp=%b", name, c, obs_ctrl, exp_ctrl);
      end
      exp_d = (claim_a && rdy_c) ? exp_rd : 32'd0;
      checks++;
      if (a_rd !== exp_d) begin
        failures++;
        $display("FAIL %s cyc%0d rd_a got=%h exp=%h", name, c, a_rd, exp_d);
      end
      if (claim_a && disp) begin
        checks++;
        if ({a_unit_insn, a_unit_rs1, a_unit_rs2} !== {insn, rs1, rs2}) begin
          failures++;
          $display("FAIL %s cyc%0d unit_a got=%h/%h/%h exp=%h/%h/%h", name, c,
                   a_unit_insn, a_unit_rs1, a_unit_rs2, insn, rs1, rs2);
        end
      end

      exp_ctrl = {claim_b && disp, 1'b0, claim_b && wait_c,
                  claim_b && rdy_c, claim_b && rdy_c && exp_wr, claim_b && rdy_c && exp_err};
      obs_ctrl = {b_mul_valid, b_div_valid, b_wait, b_ready, b_wr, b_err};
      checks++;
      if (obs_ctrl !== exp_ctrl) begin
        failures++;
        $display("FAIL %s cyc%0d ctrl_b(mv,dv,wait,rdy,wr,err) got=%b exp=%b", name, c, obs_ctrl, exp_ctrl);
      end
      exp_d = (claim_b && rdy_c) ? exp_rd : 32'd0;
      checks++;
      if (b_rd !== exp_d) begin
        failures++;
        $display("FAIL %s cyc%0d rd_b got=%h exp=%h", name, c, b_rd, exp_d);
      end
    end
    @(negedge clk);
    pcpi_valid = 1'b0;
    mul_ready  = 1'b0;
    div_ready  = 1'b0;
    #1;
    checks++;
    if ({a_mul_valid, a_div_valid, a_wait, a_ready, a_wr, a_err, a_rd,
         b_mul_valid, b_div_valid, b_wait, b_ready, b_wr, b_err, b_rd} !== '0) begin
      failures++;
      $display("FAIL %s release outputs not idle a_rdy=%b a_wait=%b b_rdy=%b b_wait=%b exp=0",
               name, a_ready, a_wait, b_ready, b_wait);
    end
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h02B5_0533;
    pcpi_rs1   = 32'd7;
    pcpi_rs2   = 32'd6;
    mul_ready  = 1'b1; mul_wr = 1'b1; mul_rd = 32'hDEAD_BEEF;
    div_ready  = 1'b1; div_wr = 1'b1; div_rd = 32'hCAFE_F00D;
    mul_wait   = 1'b0; div_wait = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({a_mul_valid, a_div_valid, a_wait, a_ready, a_wr, a_err, a_rd,
         a_unit_insn, a_unit_rs1, a_unit_rs2} !== '0) begin
      failures++;
      $display("FAIL reset_a got rdy=%b wait=%b mv=%b rd=%h insn=%h exp=all zero",
               a_ready, a_wait, a_mul_valid, a_rd, a_unit_insn);
    end
    checks++;
    if ({b_mul_valid, b_div_valid, b_wait, b_ready, b_wr, b_err, b_rd,
         b_unit_insn, b_unit_rs1, b_unit_rs2} !== '0) begin
      failures++;
      $display("FAIL reset_b got rdy=%b wait=%b mv=%b rd=%h insn=%h exp=all zero",
               b_ready, b_wait, b_mul_valid, b_rd, b_unit_insn);
    end
    pcpi_valid = 1'b0;
    mul_ready  = 1'b0;
    div_ready  = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    run_txn("mul_7x6", 32'h02B5_0533, 32'd7, 32'd6, 2, 32'd42, 1'b1, 3);
  endtask

  task automatic test_div();
    run_txn("div_100_7", 32'h02B5_4533, 32'd100, 32'd7, 5, 32'd14, 1'b1, 0);
  endtask

  task automatic test_non_m();
    run_txn("add_not_m", 32'h00B5_0533, 32'd1, 32'd2, 0, 32'd0, 1'b0, 20);
    run_txn("opimm_f7_1", 32'h02B5_0513, 32'd1, 32'd2, 0, 32'd0, 1'b0, 5);
  endtask

  task automatic test_watchdog();
    run_txn("wd_div_never", 32'h02B5_4533, 32'd9, 32'd3, 0, 32'd3, 1'b1, 1);
    run_txn("wd_div_edge", 32'h02B5_4533, 32'd9, 32'd3, WD, 32'd3, 1'b1, 1);
    run_txn("wd_mul_late", 32'h02B5_0533, 32'd5, 32'd5, WD + 2, 32'd25, 1'b1, 3);
  endtask

  task automatic test_abort();
    logic [5:0] obs;
    @(negedge clk);
    pcpi_valid = 1'b1; pcpi_insn = 32'h02B5_0533; pcpi_rs1 = 32'd11; pcpi_rs2 = 32'd13;
    mul_ready = 1'b0; div_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({a_mul_valid, a_wait, a_ready} !== 3'b110) begin
      failures++;
      $display("FAIL abort_dispatch got mv/wait/rdy=%b%b%b exp=110", a_mul_valid, a_wait, a_ready);
    end
    @(negedge clk);
    pcpi_valid = 1'b0;
    #1;
    obs = {a_mul_valid, a_div_valid, a_wait, a_ready, a_wr, a_err};
    checks++;
    if (obs !== 6'b101000 || a_rd !== 32'd0) begin
      failures++;
      $display("FAIL abort_drop got ctrl=%b rd=%h exp ctrl=101000 rd=0", obs, a_rd);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mul_ready = (c == 0);
      mul_wr    = 1'b1;
      mul_rd    = 32'd143;
      #1;
      checks++;
      if ({a_mul_valid, a_div_valid, a_wait, a_ready, a_wr, a_err, a_rd,
           b_mul_valid, b_wait, b_ready, b_rd} !== '0) begin
        failures++;
        $display("FAIL abort_late_resp cyc%0d got a_rdy=%b a_rd=%h b_rdy=%b exp=0",
                 c, a_ready, a_rd, b_ready);
      end
    end
    mul_ready = 1'b0;
    run_txn("after_abort", 32'h02B5_0533, 32'd11, 32'd13, 3, 32'd143, 1'b1, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    pcpi_valid = 1'b1; pcpi_insn = 32'h02B5_3533; pcpi_rs1 = 32'hFFFF_0000; pcpi_rs2 = 32'd4;
    mul_ready = 1'b0; div_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({a_mul_valid, a_div_valid, a_wait, a_ready, a_wr, a_err, a_rd,
         a_unit_insn, a_unit_rs1, a_unit_rs2, b_mul_valid, b_wait, b_unit_insn} !== '0) begin
      failures++;
      $display("FAIL reset_mid got a_mv=%b a_wait=%b a_insn=%h b_mv=%b exp=all zero",
               a_mul_valid, a_wait, a_unit_insn, b_mul_valid);
    end
    @(negedge clk);
    pcpi_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run_txn("after_reset", 32'h02B5_3533, 32'hFFFF_0000, 32'd4, 4,
            m_ref(3'd3, 32'hFFFF_0000, 32'd4), 1'b1, 0);
  endtask

  task automatic test_enable_div();
    run_txn("nodiv_div", 32'h02B5_4533, 32'd50, 32'd5, 3, 32'd10, 1'b1, 2);
    run_txn("nodiv_mul", 32'h02B5_1533, 32'h8000_0000, 32'h8000_0000, 1,
            m_ref(3'd1, 32'h8000_0000, 32'h8000_0000), 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] insn, rs1, rs2;
    logic [2:0]  f3;
    int lat;
    for (int n = 0; n < 40; n++) begin
      f3   = 3'($urandom_range(0, 7));
      insn = {7'b0000001, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0110011};
      if ($urandom_range(0, 5) == 0) insn[31:25] = 7'($urandom_range(2, 127));
      rs1  = $urandom;
      rs2  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      lat  = $urandom_range(0, WD + 2);
      run_txn("random", insn, rs1, rs2, lat, m_ref(f3, rs1, rs2),
              1'($urandom_range(0, 3) != 0), $urandom_range(0, 3) + ((insn[31:25] == 7'b0000001) ? 0 : 4));
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_non_m();
    test_watchdog();
    test_abort();
    test_reset_mid();
    test_enable_div();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
